// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access sizes and FSM states.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: extract+extend for loads, lane merge for stores.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0] bsh;
    logic [4:0] hsh;
    logic [7:0] b;
    logic [15:0] h;

    // Offset 0 is the most significant lane.
    assign bsh = {~offset, 3'b000};
    assign hsh = {~offset[1], 4'b0000};
    assign b   = word[bsh +: 8];
    assign h   = word[hsh +: 16];

    always_comb begin
        load_data  = word;
        store_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
                store_data = word;
                store_data[bsh +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data  = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
                store_data = word;
                store_data[hsh +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with read-modify-write for sub-word stores.
// Define LSU_ALIGN_CHECK_EN to reject misaligned accesses instead of aligning.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic [31:0]           mem_address,
    output logic [31:0]           mem_data_write,
    output logic                  mem_write_en,
    output logic                  mem_read_en,
    input  logic [31:0]           mem_data_out
);

    lsu_state_e state;

    logic                  write_q;
    logic                  uns_q;
    logic                  err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_q;

    logic                  req_err;
    logic [ADDR_WIDTH-1:0] addr_clr;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           addr32;
    logic [31:0]           load_data;
    logic [31:0]           merge_data;
    logic                  access;

    always_comb begin
        word_idx = req_addr >> 2;
        addr_clr = req_addr;
        if (req_size == SZ_HALF) addr_clr[0] = 1'b0;
        if (req_size == SZ_WORD) addr_clr[1:0] = 2'b00;
        req_err = (req_size == SZ_ILL) ||
                  (word_idx >= ADDR_WIDTH'(MEM_WORDS));
`ifdef LSU_ALIGN_CHECK_EN
        if (req_size == SZ_HALF && req_addr[0]) req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        uns_q   <= req_unsigned;
                        err_q   <= req_err;
                        size_q  <= req_size;
                        addr_q  <= addr_clr;
                        wdata_q <= req_wdata;
                        if (req_err)
                            state <= RESP;
                        else if (req_write && req_size == SZ_WORD)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: begin
                    word_q <= mem_data_out;
                    state  <= write_q ? WR : RESP;
                end
                WR:   state <= RESP;
                RESP: state <= IDLE;
            endcase
        end
    end

    lsu_lane_align u_lane (
        .word        (word_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .store_data  (merge_data)
    );

    assign addr32 = 32'(addr_q);
    assign access = (state == RD) || (state == WR);

    assign req_ready      = (state == IDLE);
    assign mem_read_en    = (state == RD);
    assign mem_write_en   = (state == WR);
    assign mem_address    = access ? {addr32[31:2], 2'b00} : 32'b0;
    assign mem_data_write = (state == WR) ? merge_data : 32'b0;
    assign resp_valid     = (state == RESP);
    assign resp_err       = (state == RESP) && err_q;
    assign resp_rdata     = (state == RESP && !err_q && !write_q) ?
                            load_data : 32'b0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter MEM_WORDS, default 32, data-RAM depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  CPU access request.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_write  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  00=byte, 01=halfword, 10=word; 11 is illegal.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend sub-word loads (lbu/lhu).
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-012 SHALL have ports resp_valid, resp_err (output, 1), resp_rdata (output, 32): completion pulse, error flag, load result.
REQ-013 SHALL have ports mem_address (output, 32), mem_data_write (output, 32), mem_write_en, mem_read_en (output, 1), mem_data_out (input, 32): data-RAM initiator side; the RAM reads combinationally and indexes by address>>2.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL register all request fields on req_valid&&req_ready; IDLE->RD for loads and sub-word stores, IDLE->WR for word stores, IDLE->RESP for error requests.
REQ-016 SHALL in RD drive mem_read_en=1 and mem_address={addr[31:2],2'b00}, capture mem_data_out at cycle end; RD->RESP for loads, RD->WR for sub-word stores.
REQ-017 SHALL in WR drive mem_write_en=1 for exactly one cycle; word store writes req_wdata, sub-word store writes captured word with the addressed lane(s) replaced (read-modify-write); WR->RESP.
REQ-018 SHALL in RESP pulse resp_valid for one cycle, then return to IDLE.
REQ-019 SHALL use big-endian lanes: byte offset 0 = bits[31:24], halfword offset 0 = bits[31:16].
REQ-020 SHALL sign-extend sub-word loads unless req_unsigned; resp_rdata=0 for stores and errors.
REQ-021 SHALL flag resp_err=1 with no RAM access for req_size=11 or (addr>>2)>=MEM_WORDS.
REQ-022 SHALL keep mem_read_en, mem_write_en, mem_data_write at 0 outside RD/WR.
REQ-023 Latency from accept cycle N: error resp at N+1, word load/store at N+2, sub-word store at N+3.
REQ-024 SHALL ignore req_valid while req_ready=0; no request queueing.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all mem_* outputs 0, including mid-access (an in-flight RMW is abandoned, no write issued).

Configuration
REQ-026 With LSU_ALIGN_CHECK_EN defined, halfword with addr[0]!=0 or word with addr[1:0]!=0 SHALL produce resp_err=1 and no RAM access.
REQ-027 Without LSU_ALIGN_CHECK_EN, the misaligned low address bits SHALL be cleared (halfword addr[0], word addr[1:0]) and the access proceeds normally.

Structure
REQ-028 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enumeration.
REQ-029 Lane extraction/merge SHALL be a combinational sub-module lsu_lane_align (extract+extend for loads, merge for stores).

Verification
REQ-030 RAM[1]=0x11223344; lw addr 0x4 -> resp_rdata=0x11223344, resp_valid at N+2, one mem_read_en cycle.
REQ-031 RAM[2]=0x80FF7F01; lb addr 0x9 -> 0xFFFFFFFF; lbu addr 0x9 -> 0x000000FF; lh addr 0xA -> 0x00007F01.
REQ-032 RAM[3]=0xAABBCCDD; sb 0x55 addr 0xE -> RAM[3]=0xAABB55DD, mem_write_en high exactly one cycle, resp at N+3.
REQ-033 sw 0x12345678 addr 0x80 (MEM_WORDS=32) -> resp_err=1 at N+1, no mem_write_en.
REQ-034 lw addr 0x6: with LSU_ALIGN_CHECK_EN -> resp_err=1; without -> reads RAM[1].
REQ-035 reset_n low during WR of sub-word store -> no write occurs, outputs at reset values, req_ready=1 after release.
